clock_period_meter: RTL and testbench
=====================================

// Module: clock_period_meter
//
// PURPOSE
// Measures a slow, asynchronous clock/toggle signal in cycles of the fast system clock.
// It is the receiving end of the clock-divider path: the divider turns a count into a clock,
// and this block turns that clock back into a count.
// Reports the rising-to-rising period and the high time over a valid/ack handshake.
// Used to check divided clocks and slow strobes feeding the pipeline.
//
// PARAMETERS
// CNT_W  16  width of the cycle counter and of the period/high_time outputs; MAX = 2^CNT_W-1
//
// PORTS
// clk_500    in   1      fast system clock; all state updates on its posedge
// rst        in   1      synchronous, active-high reset
// clk_in     in   1      slow signal to measure; asynchronous to clk_500
// start      in   1      one-cycle request to begin a measurement (sampled in IDLE only)
// ack        in   1      consumer accepts result (sampled in DONE only)
// busy       out  1      1 in ARM, WAIT_EDGE or MEASURE
// valid      out  1      1 in DONE; result fields stable while valid
// period     out  CNT_W  clk_500 cycles between two consecutive rising edges of clk_in
// high_time  out  CNT_W  clk_500 cycles clk_in was high within that period
// timeout    out  1      last measurement ended by counter saturation
//
// BEHAVIOUR
// - Reset: state=IDLE; busy=0, valid=0, period=0, high_time=0, timeout=0, cnt=0.
//   Both sync flops and the edge-history flop are also cleared to 0.
// - Sync and edge detect:
//   - clk_in passes through 2 flops to give s; p holds s delayed by one cycle.
//   - rise = s & ~p; fall = ~s & p.
//   - Edge latency is 3 clk_500 cycles from the clk_in transition; rise and fall are mutually exclusive.
// - FSM:
//   - IDLE: start=1 -> ARM; clear cnt and timeout.
//   - ARM: waits for s==0 so that a high level present at start, or a false rise after reset,
//     is never taken as an edge. s==0 -> WAIT_EDGE.
//   - WAIT_EDGE: cnt increments every cycle.
//     - rise -> MEASURE with cnt<=0.
//     - cnt==MAX with no rise -> DONE with period=0, high_time=0, timeout=1.
//   - MEASURE: cnt increments every cycle.
//     - fall: high_time<=cnt+1.
//     - rise: period<=cnt+1 -> DONE.
//     - cnt==MAX with no rise: period<=MAX, timeout<=1 -> DONE.
//       high_time<=MAX if no fall was seen, otherwise it keeps the captured value.
//   - DONE: valid=1; all outputs held.
//     - ack -> IDLE; valid drops on the following cycle.
// - ARM also times out: cnt counts in ARM; cnt==MAX -> DONE with timeout=1 and zero results.
// - start is ignored outside IDLE.
// - ack is ignored outside DONE.
// - start and ack in the same cycle in DONE: ack is honoured, start is dropped and must be re-issued.
// - period and high_time update only on capture.
// - Results of a previous measurement stay readable in IDLE until the next capture;
//   valid is the only qualifier.
// - Counter arithmetic is unsigned, CNT_W bits, and saturates at MAX; it never wraps.
// - rst mid-operation returns to IDLE the next cycle with every output at its reset value.
//   Any partial result is discarded.
//
// TESTING
// 1. clk_in toggles every 101 clk_500 cycles, start pulse
//    -> valid=1 with period=202, high_time=101, timeout=0.
// 2. clk_in high for 30 cycles, low for 70, repeating
//    -> period=100, high_time=30; valid stays 1 for 40 cycles without ack.
// 3. CNT_W=8, clk_in held 0, start
//    -> DONE after 255 cycles in WAIT_EDGE with period=0, high_time=0, timeout=1.
// 4. clk_in already high at start
//    -> block stays in ARM until s==0; the first measured rise is genuine and period is correct (e.g. 202).
// 5. rst asserted 20 cycles into MEASURE
//    -> next cycle busy=0, valid=0, period=0; a later start measures normally.
// 6. In DONE, start and ack asserted together
//    -> valid=0 the next cycle, state IDLE, no new measurement.
//    A subsequent ack in IDLE has no effect.

Source files
------------

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous clk_in in clk_500 cycles.
// Results are reported over a valid/ack handshake; the counter saturates and is reported as a timeout.
module clock_period_meter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_500,
   input  logic             rst,
   input  logic             clk_in,
   input  logic             start,
   input  logic             ack,
   output logic             busy,
   output logic             valid,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             timeout
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARM     = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_MEASURE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             r_sync1;
   logic             r_s;
   logic             r_p;
   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_fall_seen;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_high_time;
   logic             r_timeout;

   logic             w_rise;
   logic             w_fall;
   logic             w_cnt_max;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_rise    = r_s & ~r_p;
   assign w_fall    = ~r_s & r_p;
   assign w_cnt_max = (r_cnt == CNT_MAX);
   // Saturating increment: the +1 forms of period/high_time also never wrap.
   assign w_cnt_inc = w_cnt_max ? CNT_MAX : (r_cnt + CNT_ONE);

   always_ff @(posedge clk_500) begin
      if (rst) begin
         r_sync1     <= 1'b0;
         r_s         <= 1'b0;
         r_p         <= 1'b0;
         r_state     <= S_IDLE;
         r_cnt       <= CNT_ZERO;
         r_fall_seen <= 1'b0;
         r_period    <= CNT_ZERO;
         r_high_time <= CNT_ZERO;
         r_timeout   <= 1'b0;
      end else begin
         r_sync1 <= clk_in;
         r_s     <= r_sync1;
         r_p     <= r_s;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_ARM;
                  r_cnt       <= CNT_ZERO;
                  r_timeout   <= 1'b0;
                  r_fall_seen <= 1'b0;
               end
            end
            // A level already high at start must drop before any rise is trusted.
            S_ARM: begin
               if (!r_s) begin
                  r_state <= S_WAIT;
                  r_cnt   <= CNT_ZERO;
               end else if (w_cnt_max) begin
                  r_state     <= S_DONE;
                  r_timeout   <= 1'b1;
                  r_period    <= CNT_ZERO;
                  r_high_time <= CNT_ZERO;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_WAIT: begin
               if (w_rise) begin
                  r_state     <= S_MEASURE;
                  r_cnt       <= CNT_ZERO;
                  r_fall_seen <= 1'b0;
               end else if (w_cnt_max) begin
                  r_state     <= S_DONE;
                  r_timeout   <= 1'b1;
                  r_period    <= CNT_ZERO;
                  r_high_time <= CNT_ZERO;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_MEASURE: begin
               r_cnt <= w_cnt_inc;
               if (w_fall) begin
                  r_high_time <= w_cnt_inc;
                  r_fall_seen <= 1'b1;
               end
               if (w_rise) begin
                  r_period <= w_cnt_inc;
                  r_state  <= S_DONE;
               end else if (w_cnt_max) begin
                  r_period  <= CNT_MAX;
                  r_timeout <= 1'b1;
                  r_state   <= S_DONE;
                  if (!r_fall_seen) begin
                     r_high_time <= CNT_MAX;
                  end
               end
            end
            S_DONE: begin
               if (ack) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = (r_state == S_ARM) || (r_state == S_WAIT) || (r_state == S_MEASURE);
   assign valid     = (r_state == S_DONE);
   assign period    = r_period;
   assign high_time = r_high_time;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: a 16-bit instance for normal measurements
// and an 8-bit instance for the saturation timeout.
module tb_clock_period_meter;

   logic        clk_500 = 1'b0;
   logic        rst = 1'b1;
   logic        clk_in = 1'b0;
   logic        start = 1'b0;
   logic        ack = 1'b0;
   logic        busy, valid, timeout;
   logic [15:0] period, high_time;

   logic        clk_in_b = 1'b0;
   logic        start_b = 1'b0;
   logic        ack_b = 1'b0;
   logic        busy_b, valid_b, timeout_b;
   logic [7:0]  period_b, high_time_b;

   logic        gen_on = 1'b0;
   logic        hold_lvl = 1'b0;
   int          hi_len = 101;
   int          lo_len = 101;

   int          n_checks = 0;
   int          n_errors = 0;

   clock_period_meter #(.CNT_W(16)) u_dut (
      .clk_500(clk_500), .rst(rst), .clk_in(clk_in), .start(start), .ack(ack),
      .busy(busy), .valid(valid), .period(period), .high_time(high_time), .timeout(timeout)
   );

   clock_period_meter #(.CNT_W(8)) u_dut8 (
      .clk_500(clk_500), .rst(rst), .clk_in(clk_in_b), .start(start_b), .ack(ack_b),
      .busy(busy_b), .valid(valid_b), .period(period_b), .high_time(high_time_b), .timeout(timeout_b)
   );

   always #5 clk_500 = ~clk_500;

   // Slow clock source; changes only on negedges so the synchronizer sees clean levels.
   always begin
      if (!gen_on) begin
         clk_in = hold_lvl;
         @(negedge clk_500);
      end else begin
         clk_in = 1'b1;
         repeat (hi_len) @(negedge clk_500);
         clk_in = 1'b0;
         repeat (lo_len) @(negedge clk_500);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk_500); start = 1'b1;
      @(negedge clk_500); start = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clk_500); ack = 1'b1;
      @(negedge clk_500); ack = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n;
      n = 0;
      while (!valid && n < budget) begin
         @(negedge clk_500);
         n++;
      end
      check_eq(tag, valid, 1);
   endtask

   task automatic wait_clk_in_rise(input string tag, input int budget);
      int n;
      logic prev;
      logic seen;
      n = 0;
      seen = 1'b0;
      prev = clk_in;
      while (!seen && n < budget) begin
         @(negedge clk_500);
         if (clk_in && !prev) seen = 1'b1;
         prev = clk_in;
         n++;
      end
      check_eq(tag, seen, 1);
   endtask

   initial begin
      // Reset values
      repeat (5) @(negedge clk_500);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_valid", valid, 0);
      check_eq("rst_period", period, 0);
      check_eq("rst_high", high_time, 0);
      check_eq("rst_timeout", timeout, 0);
      rst = 1'b0;

      // 1: symmetric 101/101 toggle
      gen_on = 1'b1; hi_len = 101; lo_len = 101;
      repeat (50) @(negedge clk_500);
      pulse_start();
      check_eq("t1_busy", busy, 1);
      wait_valid("t1_valid", 1000);
      check_eq("t1_period", period, 202);
      check_eq("t1_high", high_time, 101);
      check_eq("t1_timeout", timeout, 0);
      check_eq("t1_busy_done", busy, 0);
      pulse_ack();
      check_eq("t1_valid_ack", valid, 0);
      check_eq("t1_busy_idle", busy, 0);

      // 2: 30 high / 70 low, result held without ack
      hi_len = 30; lo_len = 70;
      repeat (300) @(negedge clk_500);
      pulse_start();
      wait_valid("t2_valid", 1000);
      check_eq("t2_period", period, 100);
      check_eq("t2_high", high_time, 30);
      repeat (40) @(negedge clk_500);
      check_eq("t2_valid_held", valid, 1);
      check_eq("t2_period_held", period, 100);
      check_eq("t2_high_held", high_time, 30);
      pulse_ack();
      check_eq("t2_valid_ack", valid, 0);

      // 3: 8-bit counter, clk_in stuck low
      @(negedge clk_500); start_b = 1'b1;
      @(negedge clk_500); start_b = 1'b0;
      check_eq("t3_busy", busy_b, 1);
      repeat (200) @(negedge clk_500);
      check_eq("t3_valid_early", valid_b, 0);
      begin
         int n;
         n = 0;
         while (!valid_b && n < 200) begin
            @(negedge clk_500);
            n++;
         end
      end
      check_eq("t3_valid", valid_b, 1);
      check_eq("t3_period", period_b, 0);
      check_eq("t3_high", high_time_b, 0);
      check_eq("t3_timeout", timeout_b, 1);
      @(negedge clk_500); ack_b = 1'b1;
      @(negedge clk_500); ack_b = 1'b0;
      check_eq("t3_valid_ack", valid_b, 0);

      // 4: clk_in already high at start
      gen_on = 1'b0; hold_lvl = 1'b1;
      repeat (300) @(negedge clk_500);
      pulse_start();
      repeat (100) @(negedge clk_500);
      check_eq("t4_arm_busy", busy, 1);
      check_eq("t4_arm_valid", valid, 0);
      hi_len = 101; lo_len = 101; gen_on = 1'b1;
      wait_valid("t4_valid", 1500);
      check_eq("t4_period", period, 202);
      check_eq("t4_high", high_time, 101);
      check_eq("t4_timeout", timeout, 0);
      pulse_ack();

      // 5: reset in the middle of a measurement
      pulse_start();
      wait_clk_in_rise("t5_rise_seen", 500);
      repeat (24) @(negedge clk_500);
      check_eq("t5_busy_pre", busy, 1);
      rst = 1'b1;
      @(negedge clk_500);
      rst = 1'b0;
      check_eq("t5_busy", busy, 0);
      check_eq("t5_valid", valid, 0);
      check_eq("t5_period", period, 0);
      check_eq("t5_high", high_time, 0);
      repeat (10) @(negedge clk_500);
      pulse_start();
      wait_valid("t5_valid_again", 1000);
      check_eq("t5_period_again", period, 202);
      check_eq("t5_high_again", high_time, 101);

      // 6: start and ack together in DONE
      @(negedge clk_500); start = 1'b1; ack = 1'b1;
      @(negedge clk_500); start = 1'b0; ack = 1'b0;
      check_eq("t6_valid", valid, 0);
      check_eq("t6_busy", busy, 0);
      repeat (50) @(negedge clk_500);
      check_eq("t6_busy_later", busy, 0);
      check_eq("t6_valid_later", valid, 0);
      pulse_ack();
      check_eq("t6_ack_idle_valid", valid, 0);
      check_eq("t6_ack_idle_busy", busy, 0);
      check_eq("t6_period_kept", period, 202);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
